mac_scheduler: RTL and testbench

Sequencer and arbiter for the shared multiplier in the flight-math datapath. It owns the altitude-correction job A = (x1·k1) + (x2·k2) and the battery-estimation job B = (v·t) + c, and arbitrates between their requesters with a round-robin policy. It issues operand pairs to one external fixed-latency multiplier, issuing back-to-back or serialized per `sel_pipelined`, and accumulates the returned products. It then returns each result with a one-cycle valid strobe.

---
 rtl/mac_sched_pkg.sv | 20 ++
 rtl/mac_product_tracker.sv | 27 ++
 rtl/mac_scheduler.sv | 158 +++++++++++++++
 tb/tb_mac_scheduler.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types and constants for the flight-math
// multiplier scheduler.
package mac_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE1,
    WAIT1,
    ISSUE2,
    WAIT,
    FINISH
  } state_t;

  localparam logic EQ_ALT = 1'b0;
  localparam logic EQ_BAT = 1'b1;

  localparam int MUL_LAT_MIN = 1;
  localparam int MUL_LAT_MAX = 3;

endpackage

// File: rtl/mac_product_tracker.sv
// Marks returning products of the fixed-latency multiplier
// and counts how many are still in flight.
module mac_product_tracker #(
  parameter int MUL_LAT = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic       issue,
  output logic       ret,
  output logic [1:0] outstanding
);

  logic [MUL_LAT-1:0] vld;

  assign ret = vld[MUL_LAT-1];

  always_ff @(posedge clk) begin
    if (clear) begin
      vld         <= '0;
      outstanding <= '0;
    end else begin
      vld         <= MUL_LAT'({vld, issue});
      outstanding <= outstanding + {1'b0, issue} - {1'b0, ret};
    end
  end

endmodule

// File: rtl/mac_scheduler.sv
// Round-robin sequencer for the shared multiplier: altitude
// job x1*k1 + x2*k2 and battery job v*t + c.
import mac_sched_pkg::*;

module mac_scheduler #(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              sel_pipelined,
  input  logic              alt_req,
  input  logic [DATA_W-1:0] alt_x1,
  input  logic [DATA_W-1:0] alt_k1,
  input  logic [DATA_W-1:0] alt_x2,
  input  logic [DATA_W-1:0] alt_k2,
  input  logic              bat_req,
  input  logic [DATA_W-1:0] bat_v,
  input  logic [DATA_W-1:0] bat_t,
  input  logic [DATA_W-1:0] bat_c,
  output logic              alt_ack,
  output logic              bat_ack,
  output logic              alt_valid,
  output logic              bat_valid,
  output logic [DATA_W-1:0] alt_result,
  output logic [DATA_W-1:0] bat_result,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  output logic              mul_issue,
  input  logic [DATA_W-1:0] mul_p,
  output logic              sel_eq,
  output logic              busy,
  output logic [2:0]        cycle_count
);

  if (MUL_LAT < MUL_LAT_MIN || MUL_LAT > MUL_LAT_MAX) begin : g_lat_chk
    $error("MUL_LAT out of range");
  end

  state_t state;
  state_t state_nx;

  logic              last_bat;
  logic              pipe;
  logic [DATA_W-1:0] opa1;
  logic [DATA_W-1:0] opb1;
  logic [DATA_W-1:0] opa2;
  logic [DATA_W-1:0] opb2;
  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] acc_nx;

  logic       grant;
  logic       grant_alt;
  logic       ret;
  logic       done;
  logic [1:0] outstanding;

  mac_product_tracker #(
    .MUL_LAT(MUL_LAT)
  ) u_tracker (
    .clk        (clk),
    .clear      (!rst_n),
    .issue      (mul_issue),
    .ret        (ret),
    .outstanding(outstanding)
  );

  // Altitude wins unless battery also asks and altitude went last.
  assign grant_alt = alt_req && (!bat_req || last_bat);
  assign grant     = (state == IDLE) && enable
                     && (alt_req || bat_req);
  assign acc_nx    = acc + (ret ? mul_p : '0);
  assign done      = (outstanding == {1'b0, ret});

  assign mul_issue = (state == ISSUE1) || (state == ISSUE2);
  assign alt_ack   = (state == ISSUE1) && (sel_eq == EQ_ALT);
  assign bat_ack   = (state == ISSUE1) && (sel_eq == EQ_BAT);
  assign alt_valid = (state == FINISH) && (sel_eq == EQ_ALT);
  assign bat_valid = (state == FINISH) && (sel_eq == EQ_BAT);
  assign busy      = (state != IDLE);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    if (state == ISSUE1) begin
      mul_a = opa1;
      mul_b = opb1;
    end else if (state == ISSUE2) begin
      mul_a = opa2;
      mul_b = opb2;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (grant) state_nx = ISSUE1;
      ISSUE1: begin
        if (sel_eq == EQ_BAT) state_nx = WAIT;
        else if (pipe)        state_nx = ISSUE2;
        else                  state_nx = WAIT1;
      end
      WAIT1:  if (ret) state_nx = ISSUE2;
      ISSUE2: state_nx = WAIT;
      WAIT:   if (done) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_bat    <= 1'b1;
      sel_eq      <= EQ_ALT;
      pipe        <= 1'b0;
      opa1        <= '0;
      opb1        <= '0;
      opa2        <= '0;
      opb2        <= '0;
      acc         <= '0;
      alt_result  <= '0;
      bat_result  <= '0;
      cycle_count <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        last_bat    <= !grant_alt;
        sel_eq      <= grant_alt ? EQ_ALT : EQ_BAT;
        pipe        <= sel_pipelined;
        cycle_count <= '0;
        if (grant_alt) begin
          opa1 <= alt_x1;
          opb1 <= alt_k1;
          opa2 <= alt_x2;
          opb2 <= alt_k2;
          acc  <= '0;
        end else begin
          opa1 <= bat_v;
          opb1 <= bat_t;
          acc  <= bat_c;
        end
      end else begin
        acc <= acc_nx;
        if (state != IDLE && state != FINISH
            && cycle_count != 3'd7)
          cycle_count <= cycle_count + 3'd1;
      end
      // Result lands with the strobe, so it is final in FINISH.
      if (state == WAIT && done) begin
        if (sel_eq == EQ_BAT) bat_result <= acc_nx;
        else                  alt_result <= acc_nx;
      end
    end
  end

endmodule

// File: tb/tb_mac_scheduler.sv
// Directed bench for mac_scheduler with a job-level
// timing/result model and a latency-2 multiplier model.
module tb_mac_scheduler;

  localparam int W = 16;
  localparam int L = 2;

  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    logic signed [W-1:0] c;
    logic signed [W-1:0] d;
  } job_t;

  logic         clk = 1'b0;
  logic         rst_n, enable, sel_pipelined;
  logic         alt_req, bat_req;
  logic [W-1:0] alt_x1, alt_k1, alt_x2, alt_k2;
  logic [W-1:0] bat_v, bat_t, bat_c;
  logic         alt_ack, bat_ack, alt_valid, bat_valid;
  logic [W-1:0] alt_result, bat_result, mul_a, mul_b, mul_p;
  logic         mul_issue, sel_eq, busy;
  logic [2:0]   cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_scheduler #(.DATA_W(W), .MUL_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .sel_pipelined(sel_pipelined),
    .alt_req(alt_req), .alt_x1(alt_x1), .alt_k1(alt_k1),
    .alt_x2(alt_x2), .alt_k2(alt_k2),
    .bat_req(bat_req), .bat_v(bat_v), .bat_t(bat_t),
    .bat_c(bat_c),
    .alt_ack(alt_ack), .bat_ack(bat_ack),
    .alt_valid(alt_valid), .bat_valid(bat_valid),
    .alt_result(alt_result), .bat_result(bat_result),
    .mul_a(mul_a), .mul_b(mul_b), .mul_issue(mul_issue),
    .mul_p(mul_p), .sel_eq(sel_eq), .busy(busy),
    .cycle_count(cycle_count)
  );

  // Multiplier: product valid exactly L cycles after issue.
  logic [L-1:0] pv = '0;
  logic [W-1:0] pp [L];
  always @(posedge clk) begin
    pv    <= {pv[L-2:0], mul_issue};
    pp[0] <= mul_a * mul_b;
    for (int i = 1; i < L; i++) pp[i] <= pp[i-1];
  end
  assign mul_p = pv[L-1] ? pp[L-1] : 16'h5a5a;

  task automatic chk(input string nm,
                     input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  // Job-level model: cycle numbers of ack/issues/valid.
  int  cyc = 0;
  int  m_ack = -100, m_valid = -100;
  int  m_i1 = -100, m_i2 = -100, m_free = 0;
  int  m_cnt_hold = 0;
  bit  m_bat = 0, m_sel = 0, ptr_bat = 1, armed = 0, wa;
  logic signed [W-1:0] m_a1, m_b1, m_a2, m_b2, m_new;
  logic signed [W-1:0] m_alt_res = '0, m_bat_res = '0;

  always @(posedge clk) begin
    if (cyc == m_valid) begin
      m_cnt_hold = (m_valid - m_ack > 7) ? 7 : m_valid - m_ack;
      if (m_bat) m_bat_res = m_new;
      else       m_alt_res = m_new;
    end
    if (!rst_n) begin
      armed = 1; ptr_bat = 1; m_sel = 0; m_bat = 0;
      m_alt_res = '0; m_bat_res = '0; m_cnt_hold = 0;
      m_ack = -100; m_valid = -100;
      m_i1 = -100; m_i2 = -100; m_free = cyc + 1;
    end else if (cyc >= m_free && enable
                 && (alt_req || bat_req)) begin
      wa = alt_req && (!bat_req || ptr_bat);
      ptr_bat = !wa; m_bat = !wa; m_sel = !wa;
      m_ack = cyc + 1; m_i1 = cyc + 1;
      if (wa) begin
        m_a1 = alt_x1; m_b1 = alt_k1;
        m_a2 = alt_x2; m_b2 = alt_k2;
        m_new = alt_x1 * alt_k1 + alt_x2 * alt_k2;
        if (sel_pipelined) begin
          m_i2 = cyc + 2; m_valid = cyc + 3 + L;
        end else begin
          m_i2 = cyc + 2 + L; m_valid = cyc + 3 + 2 * L;
        end
      end else begin
        m_a1 = bat_v; m_b1 = bat_t;
        m_new = bat_v * bat_t + bat_c;
        m_i2 = -100; m_valid = cyc + 2 + L;
      end
      m_free = m_valid + 1;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("alt_ack", alt_ack, cyc == m_ack && !m_bat);
      chk("bat_ack", bat_ack, cyc == m_ack && m_bat);
      chk("alt_valid", alt_valid, cyc == m_valid && !m_bat);
      chk("bat_valid", bat_valid, cyc == m_valid && m_bat);
      chk("mul_issue", mul_issue, cyc == m_i1 || cyc == m_i2);
      chk("mul_a", $signed(mul_a),
          cyc == m_i1 ? m_a1 : cyc == m_i2 ? m_a2 : 0);
      chk("mul_b", $signed(mul_b),
          cyc == m_i1 ? m_b1 : cyc == m_i2 ? m_b2 : 0);
      chk("busy", busy, cyc >= m_ack && cyc <= m_valid);
      chk("sel_eq", sel_eq, m_sel);
      chk("cycle_count", cycle_count,
          (cyc >= m_ack && cyc <= m_valid)
          ? ((cyc - m_ack > 7) ? 7 : cyc - m_ack) : m_cnt_hold);
      chk("alt_result", $signed(alt_result),
          (cyc == m_valid && !m_bat) ? m_new : m_alt_res);
      chk("bat_result", $signed(bat_result),
          (cyc == m_valid && m_bat) ? m_new : m_bat_res);
    end
  end

  // Requesters: hold operands until ack, then present the next job.
  job_t aq[$];
  job_t bq[$];

  task automatic drive_alt(input job_t j);
    alt_x1 = j.a; alt_k1 = j.b; alt_x2 = j.c; alt_k2 = j.d;
    alt_req = 1'b1;
  endtask

  task automatic drive_bat(input job_t j);
    bat_v = j.a; bat_t = j.b; bat_c = j.c;
    bat_req = 1'b1;
  endtask

  task automatic load_alt(input job_t j);
    if (alt_req) aq.push_back(j);
    else drive_alt(j);
  endtask

  task automatic load_bat(input job_t j);
    if (bat_req) bq.push_back(j);
    else drive_bat(j);
  endtask

  task automatic tick();
    @(negedge clk);
    if (alt_ack) begin
      if (aq.size() > 0) drive_alt(aq.pop_front());
      else alt_req = 1'b0;
    end
    if (bat_ack) begin
      if (bq.size() > 0) drive_bat(bq.pop_front());
      else bat_req = 1'b0;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0: return alt_ack;
      1: return bat_ack;
      2: return alt_valid;
      default: return bat_valid;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound,
                          output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (sig(which)) begin
        at = cyc;
        break;
      end
      tick();
    end
    if (at < 0) chk($sformatf("timeout_%0d", which), 0, 1);
  endtask

  int r, t_ack, t_val, k, seen;

  initial begin
    rst_n = 0; enable = 1; sel_pipelined = 1;
    alt_req = 0; bat_req = 0;
    alt_x1 = '0; alt_k1 = '0; alt_x2 = '0; alt_k2 = '0;
    bat_v = '0; bat_t = '0; bat_c = '0;
    load_alt('{16'sd2, 16'sd5, -16'sd3, 16'sd7});
    load_alt('{16'sd200, 16'sd200, 16'sd0, 16'sd0});
    load_bat('{16'sd3, -16'sd4, 16'sd100, 16'sd0});

    // Reset with both requests high, then round-robin service.
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_alt_ack", alt_ack, 0);
      chk("rst_bat_ack", bat_ack, 0);
    end
    rst_n = 1;
    r = cyc;
    wait_for(0, 10, t_ack);
    chk("alt_ack_c1", t_ack - r, 1);
    wait_for(2, 20, t_val);
    chk("alt_pipe_valid_c5", t_val - r, 5);
    chk("alt_pipe_res", $signed(alt_result), -11);
    chk("alt_pipe_cnt", cycle_count, 4);
    wait_for(1, 20, t_ack);
    chk("bat_ack_gap", t_ack - t_val, 2);
    wait_for(3, 20, t_val);
    chk("bat_valid_c4", t_val - t_ack, 3);
    chk("bat_res", $signed(bat_result), 88);
    chk("bat_cnt", cycle_count, 3);
    chk("bat_sel_eq", sel_eq, 1);
    wait_for(0, 20, t_ack);
    chk("alt2_ack_gap", t_ack - t_val, 2);
    wait_for(2, 20, t_val);
    chk("alt_wrap_res", $signed(alt_result), -25536);

    // Serialized altitude.
    tick(); tick();
    sel_pipelined = 0;
    load_alt('{16'sd2, 16'sd5, -16'sd3, 16'sd7});
    k = cyc;
    wait_for(0, 10, t_ack);
    chk("np_ack_c1", t_ack - k, 1);
    wait_for(2, 20, t_val);
    chk("np_valid_c7", t_val - k, 7);
    chk("np_res", $signed(alt_result), -11);
    chk("np_cnt", cycle_count, 6);

    // Reset while the battery job waits on its product.
    tick(); tick();
    sel_pipelined = 1;
    load_bat('{16'sd5, 16'sd5, 16'sd1, 16'sd0});
    tick(); tick();
    chk("mid_busy", busy, 1);
    rst_n = 0;
    tick();
    rst_n = 1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bat_valid || alt_valid) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    chk("mid_rst_bat_res", $signed(bat_result), 0);
    chk("mid_rst_alt_res", $signed(alt_result), 0);

    // Grants blocked while enable is low.
    enable = 0;
    load_bat('{16'sd7, -16'sd2, 16'sd3, 16'sd0});
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bat_ack) seen++;
    end
    chk("en_low_no_ack", seen, 0);
    enable = 1;
    k = cyc;
    wait_for(1, 10, t_ack);
    chk("en_ack_next", t_ack - k, 1);
    wait_for(3, 20, t_val);
    chk("en_bat_res", $signed(bat_result), -11);

    tick(); tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
